wave_param_ctrl: RTL and testbench

WAVE_PARAM_CTRL -- requirements
Module: wave_param_ctrl

---
 rtl/wave_pkg.sv | 30 +++
 rtl/wave_chan_regs.sv | 88 ++++++++
 rtl/wave_param_ctrl.sv | 104 ++++++++++
 tb/tb_wave_param_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wave_pkg.sv
// Shared constants, command field encoding and FSM states for wave_param_ctrl.
// WAVE_SWEEP_EN adds the per-channel sweep step field (field 4).
package wave_pkg;

    localparam int DW = 16;

    localparam logic [2:0] FIELD_AMP    = 3'd0;
    localparam logic [2:0] FIELD_OFFSET = 3'd1;
    localparam logic [2:0] FIELD_PHASE  = 3'd2;
    localparam logic [2:0] FIELD_COMMIT = 3'd3;
    localparam logic [2:0] FIELD_STEP   = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_APPLY = 2'd2
    } wave_state_e;

    // Fields that land in a channel's shadow bank; everything else except commit is ignored.
    function automatic logic is_shadow_field(input logic [2:0] field);
`ifdef WAVE_SWEEP_EN
        return (field == FIELD_AMP) || (field == FIELD_OFFSET) ||
               (field == FIELD_PHASE) || (field == FIELD_STEP);
`else
        return (field == FIELD_AMP) || (field == FIELD_OFFSET) ||
               (field == FIELD_PHASE);
`endif
    endfunction

endpackage

// File: rtl/wave_chan_regs.sv
// One channel's shadow and active parameter banks; active values load as a group on 'load'.
// With WAVE_SWEEP_EN the active phaseword advances by the active step on 'tick'.
module wave_chan_regs
#(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [2:0]    wr_field,
    input  logic [DW-1:0] wr_data,
    input  logic          load,
    input  logic          tick,
    output logic [DW-1:0] amp,
    output logic [DW-1:0] offset,
    output logic [DW-1:0] phase
);
    import wave_pkg::*;

    logic [DW-1:0] sh_amp_q, sh_off_q, sh_ph_q;
    logic [DW-1:0] act_amp_q, act_off_q, act_ph_q, act_ph_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sh_amp_q <= '0;
            sh_off_q <= '0;
            sh_ph_q  <= '0;
        end else if (wr_en) begin
            case (wr_field)
                FIELD_AMP:    sh_amp_q <= wr_data;
                FIELD_OFFSET: sh_off_q <= wr_data;
                FIELD_PHASE:  sh_ph_q  <= wr_data;
                default: ;
            endcase
        end
    end

`ifdef WAVE_SWEEP_EN
    logic [DW-1:0] sh_step_q, act_step_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sh_step_q  <= '0;
            act_step_q <= '0;
        end else begin
            if (wr_en && (wr_field == FIELD_STEP)) sh_step_q <= wr_data;
            if (load) act_step_q <= sh_step_q;
        end
    end

    // A load cycle takes priority over a sweep step; the sum wraps modulo 2^DW.
    always_comb begin
        act_ph_d = act_ph_q;
        if (load) begin
            act_ph_d = sh_ph_q;
        end else if (tick) begin
            act_ph_d = act_ph_q + act_step_q;
        end
    end
`else
    logic unused_tick;
    assign unused_tick = tick;

    always_comb begin
        act_ph_d = act_ph_q;
        if (load) act_ph_d = sh_ph_q;
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            act_amp_q <= '0;
            act_off_q <= '0;
            act_ph_q  <= '0;
        end else begin
            if (load) begin
                act_amp_q <= sh_amp_q;
                act_off_q <= sh_off_q;
            end
            act_ph_q <= act_ph_d;
        end
    end

    assign amp    = act_amp_q;
    assign offset = act_off_q;
    assign phase  = act_ph_q;

endmodule

// File: rtl/wave_param_ctrl.sv
// Two-channel waveform parameter controller: shadow writes, atomic commit to active outputs.
// Optional sweep of the active phasewords is enabled with WAVE_SWEEP_EN.
module wave_param_ctrl
#(
    parameter int DW = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_ch,
    input  logic [2:0]            cmd_field,
    input  logic [DW-1:0]         cmd_data,
    input  logic                  sweep_tick,
    output logic [2*DW-1:0]       amps,
    output logic [2*DW-1:0]       offsets,
    output logic [2*DW-1:0]       phasewords,
    output logic                  commit_done,
    output logic                  dirty,
    output wave_pkg::wave_state_e dbg_state
);
    import wave_pkg::*;

    // Handshake: a command is taken on any rising edge where cmd_valid && cmd_ready;
    // cmd_ready is a pure function of state and drops only during the APPLY copy cycle.
    wave_state_e state_q, state_d;
    logic        commit_done_q, commit_done_d;
    logic        accept, shadow_wr, commit_cmd, apply;
    logic [DW-1:0] amp0, amp1, off0, off1, ph0, ph1;

    assign accept     = cmd_valid && cmd_ready;
    assign shadow_wr  = accept && is_shadow_field(cmd_field);
    assign commit_cmd = accept && (cmd_field == FIELD_COMMIT);
    assign apply      = (state_q == ST_APPLY);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            commit_done_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            commit_done_q <= commit_done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (commit_cmd)     state_d = ST_APPLY;
                else if (shadow_wr) state_d = ST_ARMED;
            end
            ST_ARMED: begin
                if (commit_cmd) state_d = ST_APPLY;
            end
            ST_APPLY: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready     = 1'b1;
        dirty         = 1'b0;
        commit_done_d = apply;
        case (state_q)
            ST_ARMED: dirty     = 1'b1;
            ST_APPLY: cmd_ready = 1'b0;
            default: ;
        endcase
    end

    wave_chan_regs #(.DW(DW)) u_ch0 (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (shadow_wr && !cmd_ch),
        .wr_field (cmd_field),
        .wr_data  (cmd_data),
        .load     (apply),
        .tick     (sweep_tick),
        .amp      (amp0),
        .offset   (off0),
        .phase    (ph0)
    );

    wave_chan_regs #(.DW(DW)) u_ch1 (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (shadow_wr && cmd_ch),
        .wr_field (cmd_field),
        .wr_data  (cmd_data),
        .load     (apply),
        .tick     (sweep_tick),
        .amp      (amp1),
        .offset   (off1),
        .phase    (ph1)
    );

    assign amps        = {amp1, amp0};
    assign offsets     = {off1, off0};
    assign phasewords  = {ph1, ph0};
    assign commit_done = commit_done_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_wave_param_ctrl.sv
// Self-checking bench for wave_param_ctrl: scoreboard of committed parameter sets.
module tb_wave_param_ctrl;

    localparam int DW = 16;
    localparam int W  = 6 * DW;
`ifdef WAVE_SWEEP_EN
    localparam bit SWEEP = 1'b1;
`else
    localparam bit SWEEP = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_ch;
    logic [2:0]            cmd_field;
    logic [DW-1:0]         cmd_data;
    logic                  sweep_tick;
    logic [2*DW-1:0]       amps, offsets, phasewords;
    logic                  commit_done;
    logic                  dirty;
    wave_pkg::wave_state_e dbg_state;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: shadow[ch][0=amp,1=offset,2=phase,3=step], plus pending-write flag.
    logic [W-1:0]  exp_q[$];
    logic [W-1:0]  last_act;
    logic [DW-1:0] sh [2][4];
    logic          mdirty;

    always #5 clk = ~clk;

    wave_param_ctrl #(.DW(DW)) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_ch      (cmd_ch),
        .cmd_field   (cmd_field),
        .cmd_data    (cmd_data),
        .sweep_tick  (sweep_tick),
        .amps        (amps),
        .offsets     (offsets),
        .phasewords  (phasewords),
        .commit_done (commit_done),
        .dirty       (dirty),
        .dbg_state   (dbg_state)
    );

    function automatic void chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    function automatic void chk1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endfunction

    function automatic void chk_int(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endfunction

    function automatic void model_reset();
        for (int c = 0; c < 2; c++)
            for (int f = 0; f < 4; f++)
                sh[c][f] = '0;
        mdirty   = 1'b0;
        last_act = '0;
        exp_q.delete();
    endfunction

    function automatic logic [W-1:0] snapshot();
        return {sh[1][0], sh[0][0], sh[1][1], sh[0][1], sh[1][2], sh[0][2]};
    endfunction

    function automatic void model_accept(input logic ch, input logic [2:0] f, input logic [DW-1:0] d);
        if (f <= 3'd2) begin
            sh[ch][int'(f)] = d;
            mdirty = 1'b1;
        end else if (f == 3'd4 && SWEEP) begin
            sh[ch][3] = d;
            mdirty = 1'b1;
        end else if (f == 3'd3) begin
            exp_q.push_back(snapshot());
            mdirty = 1'b0;
        end
    endfunction

    // Monitor: each commit_done consumes one expected parameter set; otherwise outputs hold.
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            if (commit_done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk1("spurious_commit_done", commit_done, 1'b0);
                end else begin
                    last_act = exp_q.pop_front();
                    chk("commit_values", {amps, offsets, phasewords}, last_act);
                end
            end else begin
`ifdef WAVE_SWEEP_EN
                chk("hold_amp_offset", {{(2*DW){1'b0}}, amps, offsets},
                    {{(2*DW){1'b0}}, last_act[W-1 -: 4*DW]});
`else
                chk("hold_outputs", {amps, offsets, phasewords}, last_act);
`endif
            end
        end
    end

    task automatic send(input logic ch, input logic [2:0] f, input logic [DW-1:0] d, output int waits);
        waits = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_ch    = ch;
        cmd_field = f;
        cmd_data  = d;
        while (cmd_ready !== 1'b1 && waits < 8) begin
            @(negedge clk);
            waits++;
        end
        if (cmd_ready !== 1'b1) begin
            chk1("ready_timeout", cmd_ready, 1'b1);
            cmd_valid = 1'b0;
            return;
        end
        @(posedge clk);
        model_accept(ch, f, d);
        #1;
        cmd_valid = 1'b0;
        chk1("ready_after_accept", cmd_ready, f != 3'd3);
        chk1("dirty_after_accept", dirty, mdirty);
    endtask

    initial begin
        int w;
        int r;
        logic [2:0]    f;
        logic [DW-1:0] ph;

        reset      = 1'b0;
        cmd_valid  = 1'b0;
        cmd_ch     = 1'b0;
        cmd_field  = '0;
        cmd_data   = '0;
        sweep_tick = 1'b0;
        model_reset();

        #1;
        chk("reset_outputs", {amps, offsets, phasewords}, '0);
        chk1("reset_ready", cmd_ready, 1'b1);
        chk1("reset_dirty", dirty, 1'b0);
        chk1("reset_commit_done", commit_done, 1'b0);
        #11 reset = 1'b1;

        // Shadow writes stay invisible until the cycle after the commit edge.
        send(1'b0, 3'd0, 16'h1000, w);
        send(1'b1, 3'd2, 16'h0200, w);
        send(1'b0, 3'd3, 16'h0000, w);
        chk("first_commit_hold", {amps, offsets, phasewords}, '0);
        @(posedge clk); #1;
        chk("first_commit_load", {amps, offsets, phasewords},
            {32'h0000_1000, 32'h0000_0000, 32'h0200_0000});
        chk1("first_commit_pulse", commit_done, 1'b1);

        // Empty commit: one not-ready cycle, no dirty, values unchanged.
        send(1'b1, 3'd3, 16'h5555, w);
        @(posedge clk); #1;
        chk1("empty_commit_ready_back", cmd_ready, 1'b1);
        chk1("empty_commit_dirty", dirty, 1'b0);

        // Write held during the APPLY cycle waits exactly one cycle.
        send(1'b0, 3'd1, 16'h0AAA, w);
        send(1'b0, 3'd3, 16'h0000, w);
        send(1'b1, 3'd1, 16'h0BBB, w);
        chk_int("held_write_wait", w, 1);
        send(1'b0, 3'd3, 16'h0000, w);

        // Reserved field changes nothing.
        send(1'b1, 3'd6, 16'hDEAD, w);
        send(1'b0, 3'd3, 16'h0000, w);

        // Reset in the middle of APPLY aborts the copy.
        send(1'b0, 3'd0, 16'h1234, w);
        send(1'b1, 3'd1, 16'hABCD, w);
        send(1'b0, 3'd3, 16'h0000, w);
        #2 reset = 1'b0;
        #1;
        chk("midapply_reset_outputs", {amps, offsets, phasewords}, '0);
        chk1("midapply_reset_dirty", dirty, 1'b0);
        chk1("midapply_reset_ready", cmd_ready, 1'b1);
        chk1("midapply_reset_done", commit_done, 1'b0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);

`ifdef WAVE_SWEEP_EN
        send(1'b0, 3'd2, 16'hFFF0, w);
        send(1'b0, 3'd4, 16'h0020, w);
        send(1'b0, 3'd3, 16'h0000, w);
        sweep_tick = 1'b1;
        ph = 16'hFFF0;
        @(posedge clk); #1;
        chk("sweep_apply_no_step", {{(4*DW){1'b0}}, phasewords}, {{(4*DW){1'b0}}, sh[1][2], ph});
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            ph = ph + sh[0][3];
            chk("sweep_step", {{(4*DW){1'b0}}, phasewords}, {{(4*DW){1'b0}}, sh[1][2], ph});
        end
        sweep_tick = 1'b0;
`else
        ph = '0;
`endif

        for (int i = 0; i < 80; i++) begin
            r = $urandom_range(0, 9);
            case (r)
                0, 1, 2, 3, 4, 5: f = 3'(r % 3);
                6, 9:             f = 3'd3;
                7:                f = 3'd4;
                default:          f = 3'($urandom_range(5, 7));
            endcase
            send(1'($urandom_range(0, 1)), f, 16'($urandom_range(0, 65535)), w);
        end
        send(1'b0, 3'd3, 16'h0000, w);

        repeat (4) @(negedge clk);
        chk_int("exp_q_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
